// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the master FSM state encoding.
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam int unsigned STATE_W = 3;

   localparam logic [STATE_W-1:0] IDLE = 3'd0;
   localparam logic [STATE_W-1:0] WR   = 3'd1;
   localparam logic [STATE_W-1:0] WR_B = 3'd2;
   localparam logic [STATE_W-1:0] RD_A = 3'd3;
   localparam logic [STATE_W-1:0] RD_R = 3'd4;
   localparam logic [STATE_W-1:0] RSP  = 3'd5;

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: turns one local read/write command into a bus
// transaction and returns data, response code and a timeout flag. All outputs registered.
module axi_lite_master
   import axi_lite_pkg::*;
#(
   parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_M_AXI_ADDR_WIDTH = 4,
   parameter int unsigned C_TIMEOUT_CYCLES   = 256
) (
   input  logic                              m_axi_aclk,
   input  logic                              m_axi_aresetn,
   input  logic                              cmd_valid,
   output logic                              cmd_ready,
   input  logic                              cmd_we,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
   output logic                              rsp_valid,
   input  logic                              rsp_ready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
   output logic [1:0]                        rsp_resp,
   output logic                              rsp_timeout,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
   output logic [2:0]                        m_axi_awprot,
   output logic                              m_axi_awvalid,
   input  logic                              m_axi_awready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
   output logic                              m_axi_wvalid,
   input  logic                              m_axi_wready,
   input  logic [1:0]                        m_axi_bresp,
   input  logic                              m_axi_bvalid,
   output logic                              m_axi_bready,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
   output logic [2:0]                        m_axi_arprot,
   output logic                              m_axi_arvalid,
   input  logic                              m_axi_arready,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
   input  logic [1:0]                        m_axi_rresp,
   input  logic                              m_axi_rvalid,
   output logic                              m_axi_rready
);

   localparam int unsigned DW   = C_M_AXI_DATA_WIDTH;
   localparam int unsigned AW   = C_M_AXI_ADDR_WIDTH;
   localparam int unsigned SW   = C_M_AXI_DATA_WIDTH / 8;
   localparam int unsigned TO_W = (C_TIMEOUT_CYCLES == 0) ? 1 : $clog2(C_TIMEOUT_CYCLES + 1);
   localparam logic            TO_EN    = (C_TIMEOUT_CYCLES != 0);
   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(C_TIMEOUT_CYCLES);

   logic [STATE_W-1:0] state_q, state_d;
   logic [AW-1:0]      addr_q, addr_d;
   logic [DW-1:0]      wdata_q, wdata_d;
   logic [SW-1:0]      wstrb_q, wstrb_d;
   logic [TO_W-1:0]    cnt_q, cnt_d;
   logic               cmd_ready_q, cmd_ready_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [DW-1:0]      rdata_q, rdata_d;
   logic [1:0]         resp_q, resp_d;
   logic               timeout_q, timeout_d;
   logic               awvalid_q, awvalid_d;
   logic               wvalid_q, wvalid_d;
   logic               bready_q, bready_d;
   logic               arvalid_q, arvalid_d;
   logic               rready_q, rready_d;
   logic               bus_phase;
   logic               aw_done, w_done;

   // State and output registers
   always_ff @(posedge m_axi_aclk) begin
      if (!m_axi_aresetn) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         cnt_q       <= '0;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
         resp_q      <= 2'b00;
         timeout_q   <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         cnt_q       <= cnt_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rdata_q     <= rdata_d;
         resp_q      <= resp_d;
         timeout_q   <= timeout_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      cnt_d       = cnt_q;
      cmd_ready_d = cmd_ready_q;
      rsp_valid_d = rsp_valid_q;
      rdata_d     = rdata_q;
      resp_d      = resp_q;
      timeout_d   = timeout_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;

      bus_phase = (state_q == WR) || (state_q == WR_B) || (state_q == RD_A) || (state_q == RD_R);
      aw_done   = !awvalid_q || m_axi_awready;
      w_done    = !wvalid_q || m_axi_wready;

      // Timeout only flags; the transaction keeps waiting for the slave
      if (TO_EN && bus_phase && (cnt_q != TO_LIMIT)) begin
         cnt_d = cnt_q + TO_W'(1);
         if (cnt_d == TO_LIMIT) timeout_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               addr_d      = cmd_addr;
               wdata_d     = cmd_wdata;
               wstrb_d     = cmd_wstrb;
               cmd_ready_d = 1'b0;
               cnt_d       = '0;
               timeout_d   = 1'b0;
               if (cmd_we) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = WR;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = RD_A;
               end
            end
         end
         WR: begin
            if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
            if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
            if (aw_done && w_done) begin
               bready_d = 1'b1;
               state_d  = WR_B;
            end
         end
         WR_B: begin
            if (m_axi_bvalid && bready_q) begin
               resp_d      = m_axi_bresp;
               rdata_d     = '0;
               bready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = RSP;
            end
         end
         RD_A: begin
            if (m_axi_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_R;
            end
         end
         RD_R: begin
            if (m_axi_rvalid && rready_q) begin
               rdata_d     = m_axi_rdata;
               resp_d      = m_axi_rresp;
               rready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = RSP;
            end
         end
         RSP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign cmd_ready     = cmd_ready_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_rdata     = rdata_q;
   assign rsp_resp      = resp_q;
   assign rsp_timeout   = timeout_q;
   assign m_axi_awaddr  = addr_q;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = wstrb_q;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_bready  = bready_q;
   assign m_axi_araddr  = addr_q;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master against a small register-bank slave with adjustable handshake delays.
module tb_axi_lite_master;
   import axi_lite_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [3:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [3:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   axi_lite_master #(
      .C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(4), .C_TIMEOUT_CYCLES(8)
   ) dut (
      .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .rsp_timeout(rsp_timeout),
      .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
      .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
      .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
      .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
   );

   // Slave configuration, set by the test tasks
   int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
   logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
   logic        r_force = 1'b0;
   logic [31:0] r_force_data = 32'h0;

   logic [31:0] regs [0:3] = '{32'h0, 32'h0, 32'h0, 32'h0};
   logic        aw_got, w_got, ar_got;
   logic [3:0]  aw_addr_l, ar_addr_l;
   logic [31:0] w_data_l;
   logic [3:0]  w_strb_l;
   int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
   int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;

   // Register-bank slave with registered ready/valid and programmable delays
   always @(posedge clk) begin
      if (!rst_n) begin
         awready <= 0; wready <= 0; bvalid <= 0; bresp <= 0;
         arready <= 0; rvalid <= 0; rdata <= 0; rresp <= 0;
         aw_got <= 0; w_got <= 0; ar_got <= 0;
         aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
      end else begin
         if (awvalid && awready) begin
            awready <= 0; aw_got <= 1; aw_addr_l <= awaddr; aw_wait <= 0; aw_hs <= aw_hs + 1;
         end else if (awvalid && !awready && !aw_got) begin
            if (aw_wait >= aw_delay) awready <= 1; else aw_wait <= aw_wait + 1;
         end
         if (wvalid && wready) begin
            wready <= 0; w_got <= 1; w_data_l <= wdata; w_strb_l <= wstrb; w_wait <= 0; w_hs <= w_hs + 1;
         end else if (wvalid && !wready && !w_got) begin
            if (w_wait >= w_delay) wready <= 1; else w_wait <= w_wait + 1;
         end
         if (aw_got && w_got && !bvalid) begin
            if (b_wait >= b_delay) begin
               for (int b = 0; b < 4; b++)
                  if (w_strb_l[b]) regs[aw_addr_l[3:2]][8*b +: 8] <= w_data_l[8*b +: 8];
               bvalid <= 1; bresp <= b_resp_cfg; aw_got <= 0; w_got <= 0; b_wait <= 0;
            end else b_wait <= b_wait + 1;
         end
         if (bvalid && bready) begin bvalid <= 0; b_hs <= b_hs + 1; end
         if (arvalid && arready) begin
            arready <= 0; ar_got <= 1; ar_addr_l <= araddr; ar_wait <= 0; ar_hs <= ar_hs + 1;
         end else if (arvalid && !arready && !ar_got) begin
            if (ar_wait >= ar_delay) arready <= 1; else ar_wait <= ar_wait + 1;
         end
         if (ar_got && !rvalid) begin
            if (r_wait >= r_delay) begin
               rvalid <= 1; rdata <= r_force ? r_force_data : regs[ar_addr_l[3:2]];
               rresp <= r_resp_cfg; ar_got <= 0; r_wait <= 0;
            end else r_wait <= r_wait + 1;
         end
         if (rvalid && rready) begin rvalid <= 0; r_hs <= r_hs + 1; end
      end
   end

   // Valid/payload stability monitor: a pending valid must hold with unchanged payload
   int          viol = 0;
   logic        p_aw, p_w, p_ar;
   logic [3:0]  p_awaddr, p_araddr, p_wstrb;
   logic [31:0] p_wdata;
   always @(posedge clk) begin
      if (!rst_n) begin
         p_aw <= 0; p_w <= 0; p_ar <= 0;
      end else begin
         if (p_aw && (!awvalid || awaddr != p_awaddr)) viol <= viol + 1;
         if (p_w && (!wvalid || wdata != p_wdata || wstrb != p_wstrb)) viol <= viol + 1;
         if (p_ar && (!arvalid || araddr != p_araddr)) viol <= viol + 1;
         p_aw <= awvalid && !awready; p_awaddr <= awaddr;
         p_w  <= wvalid && !wready;   p_wdata <= wdata; p_wstrb <= wstrb;
         p_ar <= arvalid && !arready; p_araddr <= araddr;
      end
   end

   // Issue one command and collect its response; no checking here
   task automatic transact(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                           input logic [3:0] strb, input int hold,
                           output logic ok, output logic [31:0] rd, output logic [1:0] resp,
                           output logic to, output int lat, output int first_to, output int hold_bad);
      logic acc;
      ok = 0; rd = 0; resp = 0; to = 0; lat = -1; first_to = -1; hold_bad = 0; acc = 0;
      @(negedge clk);
      cmd_valid = 1; cmd_we = we; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = strb;
      for (int i = 0; i < 50; i++) begin
         if (cmd_ready) begin acc = 1; break; end
         @(negedge clk);
      end
      if (!acc) begin cmd_valid = 0; return; end
      @(posedge clk);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         cmd_valid = 0;
         if (rsp_timeout && first_to < 0) first_to = i;
         if (rsp_valid) begin lat = i; break; end
      end
      if (lat < 0) return;
      rd = rsp_rdata; resp = rsp_resp; to = rsp_timeout;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_resp !== resp ||
             rsp_timeout !== to || cmd_ready !== 1'b0) hold_bad++;
      end
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
      ok = (rsp_valid === 1'b0) && (cmd_ready === 1'b1);
   endtask

   logic        t_ok, t_to;
   logic [31:0] t_rd;
   logic [1:0]  t_resp;
   int          t_lat, t_fto, t_hb;

   task automatic test_reset();
      logic [10:0] got;
      rst_n = 0; cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
      repeat (3) @(negedge clk);
      got = {cmd_ready, rsp_valid, rsp_timeout, awvalid, wvalid, bready, arvalid, rready,
             (rsp_rdata != 0), (rsp_resp != 0), (awprot != 0 || arprot != 0)};
      n_checks++;
      if (got !== 11'b100_0000_0000) begin
         n_fail++; $display("FAIL reset_outputs got=%b exp=%b", got, 11'b100_0000_0000);
      end
      rst_n = 1;
      @(negedge clk);
      n_checks++;
      if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release cmd_ready=%b exp=1", cmd_ready); end
   endtask

   task automatic test_basic();
      transact(1, 4'h0, 32'h0000_0003, 4'hF, 0, t_ok, t_rd, t_resp, t_to, t_lat, t_fto, t_hb);
      n_checks++;
      if (!t_ok || t_resp !== RESP_OKAY || t_to !== 1'b0 || t_rd !== 32'h0) begin
         n_fail++; $display("FAIL basic_write ok=%b resp=%b to=%b rdata=%h exp 1/00/0/0", t_ok, t_resp, t_to, t_rd);
      end
      n_checks++;
      if (t_lat !== 4) begin n_fail++; $display("FAIL write_latency got=%0d exp=4", t_lat); end
      n_checks++;
      if (regs[0][1:0] !== 2'b11) begin n_fail++; $display("FAIL ddr_reset_data_en got=%b exp=11", regs[0][1:0]); end
      transact(0, 4'h0, 32'h0, 4'h0, 0, t_ok, t_rd, t_resp, t_to, t_lat, t_fto, t_hb);
      n_checks++;
      if (!t_ok || t_rd !== 32'h0000_0003 || t_resp !== RESP_OKAY) begin
         n_fail++; $display("FAIL basic_read ok=%b rdata=%h resp=%b exp 1/00000003/00", t_ok, t_rd, t_resp);
      end
      n_checks++;
      if (t_lat !== 4) begin n_fail++; $display("FAIL read_latency got=%0d exp=4", t_lat); end
   endtask

   task automatic test_strobe();
      transact(1, 4'h8, 32'h0, 4'hF, 0, t_ok, t_rd, t_resp, t_to, t_lat, t_fto, t_hb);
      transact(1, 4'h8, 32'hAABB_CCDD, 4'b0101, 0, t_ok, t_rd, t_resp, t_to, t_lat, t_fto, t_hb);
      transact(0, 4'h8, 32'h0, 4'h0, 0, t_ok, t_rd, t_resp, t_to, t_lat, t_fto, t_hb);
      n_checks++;
      if (!t_ok || t_rd !== 32'h00BB_00DD) begin
         n_fail++; $display("FAIL strobe_readback ok=%b got=%h exp=00bb00dd", t_ok, t_rd);
      end
   endtask

   task automatic test_handshake_order();
      int aw_tab [3] = '{0, 3, 2};
      int w_tab  [3] = '{3, 0, 2};
      int aw0, w0, b0, v0;
      logic [31:0] val;
      for (int i = 0; i < 3; i++) begin
         aw_delay = aw_tab[i]; w_delay = w_tab[i];
         aw0 = aw_hs; w0 = w_hs; b0 = b_hs; v0 = viol;
         val = 32'h5A00_0010 + 32'(i);
         transact(1, 4'h4, val, 4'hF, 0, t_ok, t_rd, t_resp, t_to, t_lat, t_fto, t_hb);
         n_checks++;
         if (!t_ok || t_resp !== RESP_OKAY || aw_hs - aw0 != 1 || w_hs - w0 != 1 || b_hs - b0 != 1) begin
            n_fail++;
            $display("FAIL order_%0d ok=%b resp=%b aw=%0d w=%0d b=%0d exp 1/00/1/1/1",
                     i, t_ok, t_resp, aw_hs - aw0, w_hs - w0, b_hs - b0);
         end
         n_checks++;
         if (viol != v0) begin n_fail++; $display("FAIL order_%0d_stable violations=%0d exp=0", i, viol - v0); end
         aw_delay = 0; w_delay = 0;
         transact(0, 4'h4, 32'h0, 4'h0, 0, t_ok, t_rd, t_resp, t_to, t_lat, t_fto, t_hb);
         n_checks++;
         if (t_rd !== val) begin n_fail++; $display("FAIL order_%0d_readback got=%h exp=%h", i, t_rd, val); end
      end
   endtask

   task automatic test_rsp_hold();
      r_force = 1; r_force_data = 32'h1234_5678; r_resp_cfg = RESP_SLVERR;
      transact(0, 4'hC, 32'h0, 4'h0, 5, t_ok, t_rd, t_resp, t_to, t_lat, t_fto, t_hb);
      r_force = 0; r_resp_cfg = RESP_OKAY;
      n_checks++;
      if (t_rd !== 32'h1234_5678 || t_resp !== 2'b10) begin
         n_fail++; $display("FAIL slverr_pass got=%h/%b exp=12345678/10", t_rd, t_resp);
      end
      n_checks++;
      if (t_hb != 0 || !t_ok) begin n_fail++; $display("FAIL rsp_hold unstable=%0d ok=%b exp 0/1", t_hb, t_ok); end
   endtask

   task automatic test_timeout();
      int b0;
      b_delay = 20; b0 = b_hs;
      transact(1, 4'hC, 32'hCAFE_0001, 4'hF, 0, t_ok, t_rd, t_resp, t_to, t_lat, t_fto, t_hb);
      b_delay = 0;
      n_checks++;
      if (t_fto != 8) begin n_fail++; $display("FAIL timeout_onset got=%0d exp=8", t_fto); end
      n_checks++;
      if (!t_ok || t_to !== 1'b1 || t_resp !== RESP_OKAY || b_hs - b0 != 1 || t_lat != 24) begin
         n_fail++; $display("FAIL timeout_complete ok=%b to=%b resp=%b b=%0d lat=%0d exp 1/1/00/1/24",
                            t_ok, t_to, t_resp, b_hs - b0, t_lat);
      end
      n_checks++;
      if (rsp_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky got=%b exp=1", rsp_timeout); end
      transact(0, 4'hC, 32'h0, 4'h0, 0, t_ok, t_rd, t_resp, t_to, t_lat, t_fto, t_hb);
      n_checks++;
      if (t_to !== 1'b0 || t_fto != -1 || t_rd !== 32'hCAFE_0001) begin
         n_fail++; $display("FAIL timeout_clear to=%b onset=%0d rdata=%h exp 0/-1/cafe0001", t_to, t_fto, t_rd);
      end
   endtask

   task automatic test_reset_midflight();
      logic [6:0] got;
      ar_delay = 10;
      @(negedge clk);
      cmd_valid = 1; cmd_we = 0; cmd_addr = 4'h0;
      @(negedge clk);
      cmd_valid = 0;
      @(negedge clk);
      n_checks++;
      if (arvalid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_arvalid got=%b exp=1", arvalid); end
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      ar_delay = 0;
      got = {awvalid, wvalid, arvalid, bready, rready, cmd_ready, rsp_valid};
      n_checks++;
      if (got !== 7'b0000010) begin n_fail++; $display("FAIL midflight_reset got=%b exp=0000010", got); end
      transact(0, 4'h0, 32'h0, 4'h0, 0, t_ok, t_rd, t_resp, t_to, t_lat, t_fto, t_hb);
      n_checks++;
      if (!t_ok || t_rd !== 32'h0000_0003) begin
         n_fail++; $display("FAIL post_reset_read ok=%b got=%h exp=00000003", t_ok, t_rd);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_strobe();
      test_handshake_order();
      test_rsp_hold();
      test_timeout();
      test_reset_midflight();
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
